clk_switch_monitor: RTL and testbench
=====================================

// Module: clk_switch_monitor
// PURPOSE
//  Observer at the far end of the glitch-free clock switch: samples the switched clock
//  (mon_clk) with a faster free-running clock and measures high width, low width and period.
//  Flags any phase shorter than MIN_PULSE as a glitch, and flags a stall when no edge arrives.
//  Used in-system as a health monitor and in benches as the self-checking end of the switch.
// PARAMETERS
//  W          8    width of phase-width counters (sample-clock cycles)
//  MIN_PULSE  2    shortest legal high or low phase, in clk cycles; shorter => glitch
//  TIMEOUT    64   cycles without an edge before stall asserts; must be <= 2**W-1
// PORTS
//  clk         in   1    sampling clock, must be >= 4x mon_clk frequency
//  rst         in   1    async active-high reset
//  mon_clk     in   1    switched clock under observation (asynchronous to clk)
//  clr         in   1    sync clear: measurements, glitch state, FSM -> IDLE
//  high_w      out  W    last complete high-phase width (clk cycles)
//  low_w       out  W    last complete low-phase width (clk cycles)
//  period      out  W+1  high_w + low_w of the last full cycle
//  meas_vld    out  1    1-cycle pulse when period/high_w/low_w update
//  glitch      out  1    1-cycle pulse on a short phase
//  glitch_seen out  1    sticky glitch flag, cleared only by rst/clr
//  glitch_cnt  out  8    count of short phases, saturates at 255
//  stall       out  1    high while no edge for TIMEOUT cycles
// BEHAVIOUR
//  Reset/clr: all outputs 0, sync flops 0, FSM=IDLE, width counter cnt=0. clr wins over a same-cycle edge.
//  Sync: s1<=mon_clk, s2<=s1, s3<=s2. rise = s2&~s3, fall = ~s2&s3.
//    Edge is detected 2-3 clk after the mon_clk transition.
//  cnt: loads 1 in an edge cycle, else increments. Width captured at an edge = cnt
//    (cycles since the previous detected edge). Saturates at 2**W-1.
//  FSM (one transition per edge cycle):
//    IDLE: rise->HI1; fall->WAIT. The partial first phase is discarded, nothing is captured.
//    WAIT: rise->HI1.
//    HI1 : fall -> high_w<=cnt, ->LO (no meas_vld yet).
//    LO  : rise -> low_w<=cnt, period<=high_w+cnt, meas_vld=1 next cycle, ->HI.
//    HI  : fall -> high_w<=cnt, ->LO.
//  Glitch: in HI1/HI/LO, a captured width < MIN_PULSE does all of the following:
//    - pulses glitch;
//    - sets glitch_seen;
//    - increments glitch_cnt (saturating);
//    - still updates the width, so meas_vld also fires in the LO case.
//  Stall: if cnt == TIMEOUT with no edge, then stall<=1 and FSM->IDLE.
//    stall clears in the cycle after the next detected edge. Outputs hold their last values.
//  Output latency: all outputs are registered, one clk after the edge-detect cycle.
//  mon_clk is never used as a clock inside this block.
// TESTING
//  1 clk=1ns, mon_clk 10ns period 50% -> after 2 cycles: high_w=5, low_w=5, period=10, meas_vld every 10 clk.
//  2 switch to 4ns period (2/2) mid-run -> within 2 mon_clk cycles: period=4; glitch stays 0.
//  3 inject 1ns high pulse in the low phase -> glitch pulse, glitch_seen=1, glitch_cnt=1.
//    The next stable cycle reports a normal period.
//  4 hold mon_clk low for 80 clk -> stall=1 at 64 cycles after the last edge.
//    Restart clock -> stall=0, first meas_vld after one full cycle (IDLE/HI1 path).
//  5 300 glitches -> glitch_cnt=255; then clr -> glitch_cnt=0, glitch_seen=0, FSM IDLE.
//  6 assert rst mid-HI phase -> all outputs 0 immediately; first meas_vld only after a full high+low cycle.

Source files
------------

// File: rtl/clk_switch_monitor.sv
// Health monitor for a switched clock: oversamples mon_clk with clk, measures high/low
// phase widths and period, and flags short phases (glitches) and missing edges (stall).
module clk_switch_monitor #(
    parameter int W         = 8,
    parameter int MIN_PULSE = 2,
    parameter int TIMEOUT   = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mon_clk,
    input  logic         clr,
    output logic [W-1:0] high_w,
    output logic [W-1:0] low_w,
    output logic [W:0]   period,
    output logic         meas_vld,
    output logic         glitch,
    output logic         glitch_seen,
    output logic [7:0]   glitch_cnt,
    output logic         stall
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_HI1  = 3'd2,
        ST_LO   = 3'd3,
        ST_HI   = 3'd4
    } state_t;

    localparam logic [W-1:0] CNT_ZERO  = {W{1'b0}};
    localparam logic [W-1:0] CNT_ONE   = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] CNT_MAX   = {W{1'b1}};
    localparam logic [W-1:0] TIMEOUT_C = W'(TIMEOUT);
    localparam logic [W-1:0] MIN_C     = W'(MIN_PULSE);

    state_t       state_r;
    state_t       state_nxt_s;
    logic         s1_r;
    logic         s2_r;
    logic         s3_r;
    logic [W-1:0] cnt_r;
    logic         rise_s;
    logic         fall_s;
    logic         edge_s;
    logic         cap_high_s;
    logic         cap_low_s;
    logic         short_evt_s;
    logic         set_stall_s;

    // Three-flop synchroniser; s1 is the metastability stage, s2/s3 form the edge detector
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else if (clr) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= mon_clk;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    assign rise_s = s2_r & ~s3_r;
    assign fall_s = ~s2_r & s3_r;
    assign edge_s = rise_s | fall_s;

    // Phase-width counter: cycles since the last detected edge, saturating
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= CNT_ZERO;
        end else if (clr) begin
            cnt_r <= CNT_ZERO;
        end else if (edge_s) begin
            cnt_r <= CNT_ONE;
        end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else if (clr) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state and capture strobes; a timeout drops back to IDLE so the next phase is partial
    always_comb begin
        state_nxt_s = state_r;
        cap_high_s  = 1'b0;
        cap_low_s   = 1'b0;
        set_stall_s = 1'b0;
        if ((cnt_r == TIMEOUT_C) && !edge_s) begin
            set_stall_s = 1'b1;
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (rise_s) begin
                        state_nxt_s = ST_HI1;
                    end else if (fall_s) begin
                        state_nxt_s = ST_WAIT;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (rise_s) begin
                        state_nxt_s = ST_HI1;
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end
                ST_HI1, ST_HI: begin
                    if (fall_s) begin
                        cap_high_s  = 1'b1;
                        state_nxt_s = ST_LO;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                ST_LO: begin
                    if (rise_s) begin
                        cap_low_s   = 1'b1;
                        state_nxt_s = ST_HI;
                    end else begin
                        state_nxt_s = ST_LO;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
        short_evt_s = (cap_high_s | cap_low_s) & (cnt_r < MIN_C);
    end

    // Registered measurement, glitch and stall outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            high_w      <= CNT_ZERO;
            low_w       <= CNT_ZERO;
            period      <= {1'b0, CNT_ZERO};
            meas_vld    <= 1'b0;
            glitch      <= 1'b0;
            glitch_seen <= 1'b0;
            glitch_cnt  <= 8'd0;
            stall       <= 1'b0;
        end else if (clr) begin
            high_w      <= CNT_ZERO;
            low_w       <= CNT_ZERO;
            period      <= {1'b0, CNT_ZERO};
            meas_vld    <= 1'b0;
            glitch      <= 1'b0;
            glitch_seen <= 1'b0;
            glitch_cnt  <= 8'd0;
            stall       <= 1'b0;
        end else begin
            meas_vld <= cap_low_s;
            glitch   <= short_evt_s;
            if (cap_high_s) begin
                high_w <= cnt_r;
            end
            if (cap_low_s) begin
                low_w  <= cnt_r;
                period <= {1'b0, high_w} + {1'b0, cnt_r};
            end
            if (short_evt_s) begin
                glitch_seen <= 1'b1;
                if (glitch_cnt != 8'hFF) begin
                    glitch_cnt <= glitch_cnt + 8'd1;
                end
            end
            // an edge always wins over the timeout, so stall can never set and clear together
            if (edge_s) begin
                stall <= 1'b0;
            end else if (set_stall_s) begin
                stall <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clk_switch_monitor.sv
// Self-checking bench for clk_switch_monitor: an event-level model (edge timestamps and
// phase bookkeeping) is compared every cycle, plus hand-computed checks per scenario.
`timescale 1ns/100ps
module tb_clk_switch_monitor;

    localparam int W         = 8;
    localparam int MIN_PULSE = 2;
    localparam int TIMEOUT   = 64;

    logic         clk     = 1'b0;
    logic         rst     = 1'b1;
    logic         mon_clk = 1'b0;
    logic         clr     = 1'b0;
    logic [W-1:0] high_w;
    logic [W-1:0] low_w;
    logic [W:0]   period;
    logic         meas_vld;
    logic         glitch;
    logic         glitch_seen;
    logic [7:0]   glitch_cnt;
    logic         stall;

    int checks   = 0;
    int failures = 0;
    int mv_count = 0;
    int gl_count = 0;

    // model state: sampled mon_clk per clk cycle, timestamp of the last detected edge
    bit samp[$] = '{1'b0, 1'b0, 1'b0};
    int last_edge = 3;
    bit armed     = 1'b0;
    bit seen_fall = 1'b0;
    int e_high    = 0;
    int e_low     = 0;
    int e_period  = 0;
    int e_gcnt    = 0;
    bit e_mv      = 1'b0;
    bit e_gl      = 1'b0;
    bit e_gseen   = 1'b0;
    bit e_stall   = 1'b0;

    always #0.5 clk = ~clk;

    clk_switch_monitor #(.W(W), .MIN_PULSE(MIN_PULSE), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .mon_clk     (mon_clk),
        .clr         (clr),
        .high_w      (high_w),
        .low_w       (low_w),
        .period      (period),
        .meas_vld    (meas_vld),
        .glitch      (glitch),
        .glitch_seen (glitch_seen),
        .glitch_cnt  (glitch_cnt),
        .stall       (stall)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic short_phase(input int w);
        if (w < MIN_PULSE) begin
            e_gl    = 1'b1;
            e_gseen = 1'b1;
            if (e_gcnt < 255) e_gcnt++;
        end
    endtask

    // reference model: an input level is seen by the measurement two cycles after it is sampled
    initial begin
        int n;
        int w;
        bit now_l;
        bit prev_l;
        forever begin
            @(posedge clk);
            samp.push_back(mon_clk);
            n    = samp.size() - 1;
            e_mv = 1'b0;
            e_gl = 1'b0;
            if (rst || clr) begin
                samp[n] = 1'b0; samp[n-1] = 1'b0; samp[n-2] = 1'b0;
                last_edge = n + 1;
                armed = 1'b0; seen_fall = 1'b0;
                e_high = 0; e_low = 0; e_period = 0; e_gcnt = 0;
                e_gseen = 1'b0; e_stall = 1'b0;
            end else begin
                now_l  = samp[n-2];
                prev_l = samp[n-3];
                w = n - last_edge;
                if (w > 255) w = 255;
                if (now_l != prev_l) begin
                    e_stall   = 1'b0;
                    last_edge = n;
                    if (now_l) begin
                        if (!armed) begin
                            armed = 1'b1;
                            seen_fall = 1'b0;
                        end else if (seen_fall) begin
                            e_low = w;
                            e_period = e_high + w;
                            e_mv = 1'b1;
                            short_phase(w);
                        end
                    end else if (armed) begin
                        e_high = w;
                        seen_fall = 1'b1;
                        short_phase(w);
                    end
                end else if (n - last_edge == TIMEOUT) begin
                    e_stall = 1'b1;
                    armed   = 1'b0;
                end
            end
        end
    end

    // per-cycle comparison, sampled a quarter cycle after the active edge
    initial begin
        forever begin
            @(posedge clk);
            #0.25;
            check("high_w", 32'(high_w), e_high);
            check("low_w", 32'(low_w), e_low);
            check("period", 32'(period), e_period);
            check("meas_vld", 32'(meas_vld), 32'(e_mv));
            check("glitch", 32'(glitch), 32'(e_gl));
            check("glitch_seen", 32'(glitch_seen), 32'(e_gseen));
            check("glitch_cnt", 32'(glitch_cnt), e_gcnt);
            check("stall", 32'(stall), 32'(e_stall));
            if (meas_vld === 1'b1) mv_count++;
            if (glitch === 1'b1) gl_count++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input bit lvl, input int n);
        mon_clk = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic run_clock(input int hi, input int lo, input int reps);
        for (int i = 0; i < reps; i++) begin
            drive(1'b1, hi);
            drive(1'b0, lo);
        end
    endtask

    initial begin
        int mv0;
        int gl0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_period", 32'(period), 32'd0);
        check("reset_glitch_cnt", 32'(glitch_cnt), 32'd0);

        // 10-cycle 50% clock
        run_clock(5, 5, 4);
        mv0 = mv_count;
        run_clock(5, 5, 5);
        check("t1_meas_vld_per_50", mv_count - mv0, 32'd5);
        check("t1_high_w", 32'(high_w), 32'd5);
        check("t1_low_w", 32'(low_w), 32'd5);
        check("t1_period", 32'(period), 32'd10);

        // switch to 4-cycle clock
        run_clock(2, 2, 6);
        check("t2_period", 32'(period), 32'd4);
        check("t2_high_w", 32'(high_w), 32'd2);
        check("t2_glitch_seen", 32'(glitch_seen), 32'd0);

        // single 1-cycle high pulse inside a low phase
        run_clock(5, 5, 2);
        gl0 = gl_count;
        drive(1'b1, 5); drive(1'b0, 2); drive(1'b1, 1); drive(1'b0, 2);
        drive(1'b1, 5); drive(1'b0, 5); drive(1'b1, 5);
        check("t3_glitch_pulses", gl_count - gl0, 32'd1);
        check("t3_glitch_seen", 32'(glitch_seen), 32'd1);
        check("t3_glitch_cnt", 32'(glitch_cnt), 32'd1);
        check("t3_period", 32'(period), 32'd10);

        // hold low: stall appears 64 cycles after the detected fall
        drive(1'b0, 66);
        check("t4_stall_before", 32'(stall), 32'd0);
        drive(1'b0, 1);
        check("t4_stall_at", 32'(stall), 32'd1);
        drive(1'b0, 13);
        check("t4_period_held", 32'(period), 32'd10);
        mv0 = mv_count;
        drive(1'b1, 5);
        check("t4_stall_cleared", 32'(stall), 32'd0);
        drive(1'b0, 5);
        check("t4_no_meas_yet", mv_count - mv0, 32'd0);
        drive(1'b1, 5);
        check("t4_first_meas", mv_count - mv0, 32'd1);
        check("t4_period", 32'(period), 32'd10);

        // glitch counter saturation, then clear
        run_clock(1, 1, 160);
        drive(1'b0, 5);
        check("t5_glitch_cnt_sat", 32'(glitch_cnt), 32'd255);
        check("t5_glitch_seen", 32'(glitch_seen), 32'd1);
        clr = 1'b1;
        drive(1'b0, 1);
        clr = 1'b0;
        check("t5_clr_glitch_cnt", 32'(glitch_cnt), 32'd0);
        check("t5_clr_glitch_seen", 32'(glitch_seen), 32'd0);
        check("t5_clr_high_w", 32'(high_w), 32'd0);
        check("t5_clr_period", 32'(period), 32'd0);
        mv0 = mv_count;
        run_clock(5, 5, 1);
        check("t5_no_meas_after_clr", mv_count - mv0, 32'd0);
        drive(1'b1, 5);
        check("t5_meas_after_clr", mv_count - mv0, 32'd1);
        check("t5_period", 32'(period), 32'd10);

        // asynchronous reset in the middle of a high phase
        drive(1'b0, 5);
        drive(1'b1, 2);
        #0.1;
        rst = 1'b1;
        #0.1;
        check("t6_rst_high_w", 32'(high_w), 32'd0);
        check("t6_rst_low_w", 32'(low_w), 32'd0);
        check("t6_rst_period", 32'(period), 32'd0);
        @(negedge clk);
        drive(1'b1, 2);
        rst = 1'b0;
        mv0 = mv_count;
        drive(1'b0, 5); drive(1'b1, 5); drive(1'b0, 5);
        check("t6_no_meas_partial", mv_count - mv0, 32'd0);
        drive(1'b1, 5);
        check("t6_first_meas", mv_count - mv0, 32'd1);
        check("t6_period", 32'(period), 32'd10);
        check("t6_low_w", 32'(low_w), 32'd5);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
